game_status_ctrl: RTL and testbench
===================================

Name: game_status_ctrl

Overview:
- Sequences game status for the Jack Frost screen: health, invulnerability window, score, and win/lose.
- Consumes per-object detector outputs: monster hit, monster frozen, ground block touched.
- Drives status to the renderer (player blink, finish flag) and to the score display path.
- Replaces the unsynthesizable delay-based damage logic with a counter-driven FSM.

Parameters:
- MONSTER_NUM, 2, number of monster hit/frozen inputs
- GROUND_NUM, 50, number of ground block touched inputs
- INIT_HEALTH, 3, health loaded at reset/restart (4-bit, 1..15)
- INVULN_CYCLES, 300_000_000, invulnerability length in clk cycles (3 s at 100 MHz)
- BLINK_CYCLES, 12_500_000, half-period of player blink during invulnerability
- FREEZE_SCORE, 10, points per newly frozen monster
- GROUND_SCORE, 1, points per newly iced ground block

Ports:
- clk  in  1  system clock, 100 MHz
- rstn  in  1  asynchronous active-low reset
- restart  in  1  single-cycle pulse; returns to PLAY with initial values
- hit  in  MONSTER_NUM  level, player overlaps an unfrozen monster
- frozen  in  MONSTER_NUM  level, monster currently frozen
- touched  in  GROUND_NUM  level, player standing on block
- health  out  4  remaining health
- score  out  32  accumulated score
- wudi  out  1  invulnerable (state INVULN)
- blue_visible  out  1  player sprite enable for renderer
- is_finish  out  1  game over (LOSE or WIN)
- is_win  out  1  all ground blocks iced
- dmg_pulse  out  1  one-cycle strobe per accepted hit

Behaviour:
- Single clock, clk. Reset is asynchronous and active-low on rstn. All inputs are synchronous to clk. All outputs are registered.
- Reset values: health=INIT_HEALTH, score=0, wudi=0, blue_visible=1, is_finish=0, is_win=0, dmg_pulse=0, state=PLAY, iced mask=0, counters=0, frozen history=0.
- FSM states: PLAY, INVULN, LOSE, WIN.
- PLAY, |hit=1:
  - health decrements and dmg_pulse=1 on the next cycle.
  - If the new health is 0, go to LOSE.
  - Otherwise go to INVULN and load the invulnerability counter with INVULN_CYCLES-1.
- INVULN:
  - hit is ignored.
  - The counter decrements each cycle. When it reaches 0, return to PLAY.
  - A hit still asserted on the first PLAY cycle is accepted. hit is level-sensitive by design.
- Blink: in INVULN, blue_visible toggles every BLINK_CYCLES, starting at 0 on entry. In all other states blue_visible=1.
- LOSE and WIN are terminal until restart. is_finish=1 in both; is_win=1 only in WIN.
- Freeze scoring:
  - A per-monster rising edge of frozen (registered history) adds FREEZE_SCORE in PLAY or INVULN.
  - k simultaneous rising edges add k*FREEZE_SCORE in one cycle.
  - Falling edges score nothing. Re-freezing the same monster scores again.
- Ground scoring:
  - A touched bit whose iced-mask bit is 0 sets that bit and adds GROUND_SCORE.
  - k new blocks in one cycle add k*GROUND_SCORE.
  - A block never scores twice.
- Score arithmetic:
  - Freeze and ground increments in the same cycle are summed.
  - The sum is computed 33 bits wide and score saturates at 32'hFFFF_FFFF; no wrap.
- WIN condition: the iced mask is all ones, evaluated on the registered mask. This gives one cycle of latency after the last block scores.
- Priority if WIN and LOSE qualify in the same cycle: LOSE wins.
- No scoring or health change in LOSE or WIN.
- restart:
  - Has priority over all events in that cycle.
  - Reloads all reset values except the frozen history, which loads the current frozen vector so that already-frozen monsters do not score.
  - Valid in any state, including mid-INVULN.
- Health never underflows: a hit at health=0 cannot occur, since PLAY with health 0 is unreachable.

Decomposition:
- Shared package game_pkg:
  - state enum (PLAY=2'd0, INVULN=2'd1, LOSE=2'd2, WIN=2'd3)
  - TRANSPARENT colour constants (12'h028, 12'h428)
  - score constants and INIT_HEALTH default, reused by the top and the score display.
- One sub-module, vec_popcount: combinational population count of a parameterised-width vector. It is instantiated twice: freeze rising edges, and new ground blocks.

Test Plan (sim overrides INVULN_CYCLES=20, BLINK_CYCLES=4, INIT_HEALTH=3):
- Reset then idle 50 cycles -> health=3, score=0, blue_visible=1, is_finish=0.
- hit[0] held high 100 cycles:
  - dmg_pulse at cycles 1, 22, 43.
  - health goes 3→2→1→0; LOSE after the third hit, is_finish=1, is_win=0.
  - blue_visible toggles every 4 cycles in each INVULN window.
- frozen=2'b11 rising in one cycle, then low, then frozen[1] rising again -> score 20, then 30.
- touched bits 0..49 asserted one per cycle, with bit 5 repeated -> score=50. is_win=1 one cycle after the mask fills; further events ignored.
- Same cycle: hit[1] and new frozen[0] edge in PLAY with health=3 -> health=2, score=10, state INVULN.
- restart mid-INVULN with frozen=2'b01 held -> health=3, score=0, wudi=0, state PLAY, no freeze score until frozen[0] falls and rises again.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the Jack Frost game screen.
//   state_e        - game status FSM encoding
//   TRANSPARENT_*  - sprite colour keys treated as transparent by the renderer
//   DEF_*          - default scoring / health values shared with the score display
//   sat32          - clamp a 33-bit sum to 32 bits
package game_pkg;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        INVULN = 2'd1,
        LOSE   = 2'd2,
        WIN    = 2'd3
    } state_e;

    localparam logic [11:0] TRANSPARENT_0 = 12'h028;
    localparam logic [11:0] TRANSPARENT_1 = 12'h428;

    localparam logic [3:0]  DEF_INIT_HEALTH  = 4'd3;
    localparam int unsigned DEF_FREEZE_SCORE = 10;
    localparam int unsigned DEF_GROUND_SCORE = 1;

    // Carry out of bit 31 means the score overflowed: pin it at all ones.
    function automatic logic [31:0] sat32(input logic [32:0] v);
        return v[32] ? 32'hFFFF_FFFF : v[31:0];
    endfunction

endpackage

// File: rtl/vec_popcount.sv
// vec_popcount: combinational population count.
//   vec_i [W-1:0]  - input vector
//   cnt_o [CW-1:0] - number of set bits, CW = $clog2(W+1)
module vec_popcount #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec_i,
    output logic [CW-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/game_status_ctrl.sv
// game_status_ctrl: health / invulnerability / score / win-lose sequencer.
//   clk, rstn     - 100 MHz clock, async active-low reset
//   restart       - one-cycle pulse, back to PLAY with initial values
//   hit[M]        - player overlaps an unfrozen monster (level)
//   frozen[M]     - monster currently frozen (level, rising edge scores)
//   touched[G]    - player standing on ground block (first touch scores)
//   health, score - remaining health, saturating 32-bit score
//   wudi          - invulnerable (INVULN state)
//   blue_visible  - player sprite enable (blinks while invulnerable)
//   is_finish     - LOSE or WIN; is_win - WIN only
//   dmg_pulse     - one-cycle strobe per accepted hit
// All outputs are registered.
module game_status_ctrl
    import game_pkg::*;
#(
    parameter int unsigned MONSTER_NUM   = 2,
    parameter int unsigned GROUND_NUM    = 50,
    parameter logic [3:0]  INIT_HEALTH   = DEF_INIT_HEALTH,
    parameter int unsigned INVULN_CYCLES = 300_000_000,
    parameter int unsigned BLINK_CYCLES  = 12_500_000,
    parameter int unsigned FREEZE_SCORE  = DEF_FREEZE_SCORE,
    parameter int unsigned GROUND_SCORE  = DEF_GROUND_SCORE
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   restart,
    input  logic [MONSTER_NUM-1:0] hit,
    input  logic [MONSTER_NUM-1:0] frozen,
    input  logic [GROUND_NUM-1:0]  touched,
    output logic [3:0]             health,
    output logic [31:0]            score,
    output logic                   wudi,
    output logic                   blue_visible,
    output logic                   is_finish,
    output logic                   is_win,
    output logic                   dmg_pulse
);

    localparam int unsigned FCW = $clog2(MONSTER_NUM + 1);
    localparam int unsigned GCW = $clog2(GROUND_NUM + 1);

    state_e                 state_q, state_d;
    logic [31:0]            inv_cnt_q, inv_cnt_d;
    logic [31:0]            blink_cnt_q, blink_cnt_d;
    logic [3:0]             health_q, health_d;
    logic [31:0]            score_q, score_d;
    logic [MONSTER_NUM-1:0] frz_hist_q;
    logic [GROUND_NUM-1:0]  iced_q, iced_d;
    logic                   blue_q, blue_d;
    logic                   wudi_q, wudi_d;
    logic                   fin_q, fin_d;
    logic                   win_q, win_d;
    logic                   dmg_q, dmg_d;

    // ---------------- scoring ----------------
    logic [MONSTER_NUM-1:0] frz_rise;
    logic [GROUND_NUM-1:0]  gnd_new;
    logic [FCW-1:0]         frz_cnt;
    logic [GCW-1:0]         gnd_cnt;
    logic [32:0]            frz_inc, gnd_inc, score_sum;
    logic                   active;

    assign active   = (state_q == PLAY) || (state_q == INVULN);
    assign frz_rise = frozen & ~frz_hist_q;
    assign gnd_new  = touched & ~iced_q;

    vec_popcount #(.W(MONSTER_NUM)) u_frz_pc (.vec_i(frz_rise), .cnt_o(frz_cnt));
    vec_popcount #(.W(GROUND_NUM))  u_gnd_pc (.vec_i(gnd_new),  .cnt_o(gnd_cnt));

    assign frz_inc   = 33'(frz_cnt) * 33'(FREEZE_SCORE);
    assign gnd_inc   = 33'(gnd_cnt) * 33'(GROUND_SCORE);
    assign score_sum = {1'b0, score_q} + frz_inc + gnd_inc;

    always_comb begin
        score_d = score_q;
        iced_d  = iced_q;
        if (restart) begin
            score_d = '0;
            iced_d  = '0;
        end else if (active) begin
            score_d = sat32(score_sum);
            iced_d  = iced_q | touched;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= PLAY;
            inv_cnt_q <= '0;
            health_q  <= INIT_HEALTH;
        end else begin
            state_q   <= state_d;
            inv_cnt_q <= inv_cnt_d;
            health_q  <= health_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // Win is judged on the registered mask, so it lands one cycle after
    // the last block scores. A lethal hit in the same cycle beats it.
    logic win_rdy;
    assign win_rdy = &iced_q;

    always_comb begin
        state_d   = state_q;
        inv_cnt_d = inv_cnt_q;
        health_d  = health_q;
        dmg_d     = 1'b0;
        if (restart) begin
            state_d   = PLAY;
            inv_cnt_d = '0;
            health_d  = INIT_HEALTH;
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (|hit) begin
                        health_d = health_q - 4'd1;
                        dmg_d    = 1'b1;
                    end
                    if (|hit && health_q == 4'd1) begin
                        state_d = LOSE;
                    end else if (win_rdy) begin
                        state_d = WIN;
                    end else if (|hit) begin
                        state_d   = INVULN;
                        inv_cnt_d = 32'(INVULN_CYCLES - 1);
                    end
                end
                INVULN: begin
                    if (win_rdy) begin
                        state_d = WIN;
                    end else if (inv_cnt_q == '0) begin
                        state_d = PLAY;
                    end else begin
                        inv_cnt_d = inv_cnt_q - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Blink phase restarts hidden on every entry into INVULN.
    always_comb begin
        wudi_d      = (state_d == INVULN);
        fin_d       = (state_d == LOSE) || (state_d == WIN);
        win_d       = (state_d == WIN);
        blue_d      = 1'b1;
        blink_cnt_d = '0;
        if (state_d == INVULN) begin
            if (state_q != INVULN) begin
                blue_d      = 1'b0;
                blink_cnt_d = 32'(BLINK_CYCLES - 1);
            end else if (blink_cnt_q == '0) begin
                blue_d      = ~blue_q;
                blink_cnt_d = 32'(BLINK_CYCLES - 1);
            end else begin
                blue_d      = blue_q;
                blink_cnt_d = blink_cnt_q - 32'd1;
            end
        end
    end

    // ---------------- registered outputs / datapath ----------------
    // Frozen history always tracks the input, so after restart monsters
    // that are already frozen do not score until they thaw and refreeze.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            score_q     <= '0;
            iced_q      <= '0;
            frz_hist_q  <= '0;
            blink_cnt_q <= '0;
            blue_q      <= 1'b1;
            wudi_q      <= 1'b0;
            fin_q       <= 1'b0;
            win_q       <= 1'b0;
            dmg_q       <= 1'b0;
        end else begin
            score_q     <= score_d;
            iced_q      <= iced_d;
            frz_hist_q  <= frozen;
            blink_cnt_q <= blink_cnt_d;
            blue_q      <= blue_d;
            wudi_q      <= wudi_d;
            fin_q       <= fin_d;
            win_q       <= win_d;
            dmg_q       <= dmg_d;
        end
    end

    assign health       = health_q;
    assign score        = score_q;
    assign wudi         = wudi_q;
    assign blue_visible = blue_q;
    assign is_finish    = fin_q;
    assign is_win       = win_q;
    assign dmg_pulse    = dmg_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
// tb_game_status_ctrl: directed test of game_status_ctrl with short timers
// (INVULN_CYCLES=20, BLINK_CYCLES=4). Inputs change 1 ns after the rising
// edge and outputs are sampled at the same point.
module tb_game_status_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        restart;
    logic [1:0]  hit;
    logic [1:0]  frozen;
    logic [49:0] touched;
    logic [3:0]  health;
    logic [31:0] score;
    logic        wudi, blue_visible, is_finish, is_win, dmg_pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_status_ctrl #(
        .MONSTER_NUM(2), .GROUND_NUM(50), .INIT_HEALTH(4'd3),
        .INVULN_CYCLES(20), .BLINK_CYCLES(4),
        .FREEZE_SCORE(10), .GROUND_SCORE(1)
    ) dut (
        .clk(clk), .rstn(rstn), .restart(restart),
        .hit(hit), .frozen(frozen), .touched(touched),
        .health(health), .score(score), .wudi(wudi),
        .blue_visible(blue_visible), .is_finish(is_finish),
        .is_win(is_win), .dmg_pulse(dmg_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; restart = 1'b0; hit = '0; frozen = '0; touched = '0;
        #12;
        chk("rst_health", 32'(health), 3);
        chk("rst_score", score, 0);
        chk("rst_blue", 32'(blue_visible), 1);
        chk("rst_finish", 32'(is_finish), 0);
        chk("rst_dmg", 32'(dmg_pulse), 0);
        rstn = 1'b1;
        step(50);
        chk("idle_health", 32'(health), 3);
        chk("idle_score", score, 0);
        chk("idle_blue", 32'(blue_visible), 1);
        chk("idle_finish", 32'(is_finish), 0);

        // hit held: damage at cycles 1, 22, 43; INVULN in 1..20 and 22..41
        hit = 2'b01;
        for (int k = 1; k <= 100; k++) begin
            logic inv;
            int   j, eh;
            step(1);
            inv = (k >= 1 && k <= 20) || (k >= 22 && k <= 41);
            j   = (k <= 20) ? k - 1 : k - 22;
            eh  = (k < 22) ? 2 : (k < 43) ? 1 : 0;
            chk($sformatf("hold_dmg_c%0d", k), 32'(dmg_pulse), (k == 1 || k == 22 || k == 43) ? 1 : 0);
            chk($sformatf("hold_health_c%0d", k), 32'(health), 32'(eh));
            chk($sformatf("hold_wudi_c%0d", k), 32'(wudi), 32'(inv));
            chk($sformatf("hold_blue_c%0d", k), 32'(blue_visible), inv ? 32'(((j / 4) % 2)) : 1);
            chk($sformatf("hold_finish_c%0d", k), 32'(is_finish), (k >= 43) ? 1 : 0);
        end
        chk("lose_win", 32'(is_win), 0);
        hit = '0;
        pulse_restart();
        chk("rs1_health", 32'(health), 3);
        chk("rs1_finish", 32'(is_finish), 0);

        // freeze scoring: two edges together, falling, single re-edge
        frozen = 2'b11; step(1);
        chk("frz_both", score, 20);
        frozen = 2'b00; step(1);
        chk("frz_fall", score, 20);
        frozen = 2'b10; step(1);
        chk("frz_again", score, 30);
        frozen = 2'b00; step(1);
        pulse_restart();
        chk("rs2_score", score, 0);

        // ground scoring: one block per cycle, block 5 repeated
        for (int i = 0; i < 50; i++) begin
            touched = '0; touched[i] = 1'b1;
            step(1);
            chk($sformatf("gnd_b%0d", i), score, 32'(i + 1));
            if (i == 5) begin
                step(1);
                chk("gnd_repeat5", score, 6);
            end
        end
        chk("win_not_yet", 32'(is_win), 0);
        touched = '0; step(1);
        chk("win_flag", 32'(is_win), 1);
        chk("win_finish", 32'(is_finish), 1);
        hit = 2'b01; frozen = 2'b01; touched = '1;
        step(3);
        chk("win_score_hold", score, 50);
        chk("win_health_hold", 32'(health), 3);
        chk("win_dmg", 32'(dmg_pulse), 0);
        hit = '0; touched = '0; frozen = '0;
        step(1);
        pulse_restart();
        chk("rs3_win", 32'(is_win), 0);

        // same-cycle hit and freeze edge
        hit = 2'b10; frozen = 2'b01; step(1);
        hit = '0;
        chk("mix_health", 32'(health), 2);
        chk("mix_score", score, 10);
        chk("mix_wudi", 32'(wudi), 1);
        chk("mix_dmg", 32'(dmg_pulse), 1);
        step(3);
        chk("mix_inv_score", score, 10);

        // restart mid-INVULN with frozen[0] still high
        pulse_restart();
        chk("rs4_health", 32'(health), 3);
        chk("rs4_score", score, 0);
        chk("rs4_wudi", 32'(wudi), 0);
        chk("rs4_blue", 32'(blue_visible), 1);
        step(3);
        chk("rs4_no_rescore", score, 0);
        frozen = 2'b00; step(1);
        chk("rs4_thaw", score, 0);
        frozen = 2'b01; step(1);
        chk("rs4_refreeze", score, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
